// File: rtl/pcie_user_cq_resp_if.sv
`timescale 1ns/1ps
// Bundle of the completer-request, completer-completion and register-bus
// signals of pcie_user_cq_resp. The slave modport is the responder's view;
// the master modport is the host/register-file side.
interface pcie_user_cq_resp_if #(
    parameter int DWIDTH = 256,
    parameter int REG_AW = 12
);
    logic [15:0]       cq_data_ex;
    logic [DWIDTH-1:0] cq_data;
    logic              cq_wen;
    logic              cq_ready;

    logic [15:0]       cc_data_ex;
    logic [DWIDTH-1:0] cc_data;
    logic              cc_wen;
    logic              cc_ready;

    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [REG_AW-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic [3:0]        reg_be;
    logic [31:0]       reg_rdata;
    logic              reg_rd_vld;

    logic [15:0]       odbg_info;

    modport slave (
        input  cq_data_ex, cq_data, cq_wen, cc_ready, reg_rdata, reg_rd_vld,
        output cq_ready, cc_data_ex, cc_data, cc_wen,
               reg_wr_en, reg_rd_en, reg_addr, reg_wdata, reg_be, odbg_info
    );

    modport master (
        output cq_data_ex, cq_data, cq_wen, cc_ready, reg_rdata, reg_rd_vld,
        input  cq_ready, cc_data_ex, cc_data, cc_wen,
               reg_wr_en, reg_rd_en, reg_addr, reg_wdata, reg_be, odbg_info
    );
endinterface

// File: rtl/pcie_user_cq_resp.sv
`timescale 1ns/1ps
// pcie_user_cq_resp: services single-dword host MRd/MWr requests against a
// 32-bit register bus and returns single-beat completions. Unsupported reads
// complete with UR status; other unsupported requests are discarded.
// Optional macro CQ_RD_TOUT_EN: read-wait timeout of RD_TOUT cycles that
// completes with CA status and data 32'hDEADBEEF.
module pcie_user_cq_resp #(
    parameter int DWIDTH  = 256,
    parameter int REG_AW  = 12,
    parameter int RD_TOUT = 1024
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    pcie_user_cq_resp_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR      = 4'd1,
        RD_REQ  = 4'd2,
        RD_WAIT = 4'd3,
        CPL     = 4'd4,
        DROP    = 4'd5
    } state_e;

    localparam logic [2:0] ST_SC    = 3'b000;
    localparam logic [2:0] ST_UR    = 3'b001;
    localparam logic [3:0] TYPE_MRD = 4'b0000;
    localparam logic [3:0] TYPE_MWR = 4'b0001;
`ifdef CQ_RD_TOUT_EN
    localparam logic [2:0] ST_CA    = 3'b100;
`endif

    state_e            state_q, state_d;
    logic              cq_ready_q, cq_ready_d;
    logic              cc_wen_q, cc_wen_d;
    logic [15:0]       cc_ex_q, cc_ex_d;
    logic [DWIDTH-1:0] cc_data_q, cc_data_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic              reg_rd_en_q, reg_rd_en_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]       reg_wdata_q, reg_wdata_d;
    logic [3:0]        reg_be_q, reg_be_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [15:0]       rid_q, rid_d;
    logic [7:0]        tag_q, tag_d;
    logic              mrd_q, mrd_d;
    logic [3:0]        ur_cnt_q, ur_cnt_d;
    logic [7:0]        req_cnt_q, req_cnt_d;
`ifdef CQ_RD_TOUT_EN
    logic [15:0]       tout_q, tout_d;
`endif

    logic              sop, eop, accept, is_mrd, is_mwr, dw_one;
    logic [REG_AW-1:0] beat_addr;

    assign sop       = bus.cq_data_ex[0];
    assign eop       = bus.cq_data_ex[1];
    assign accept    = bus.cq_wen & cq_ready_q;
    assign beat_addr = {bus.cq_data[REG_AW-1:2], 2'b00};
    assign dw_one    = (bus.cq_data[74:64] == 11'd1);
    assign is_mrd    = (bus.cq_data[78:75] == TYPE_MRD);
    assign is_mwr    = (bus.cq_data[78:75] == TYPE_MWR);

    logic unused_bits;
`ifdef CQ_RD_TOUT_EN
    assign unused_bits = ^{bus.cq_data_ex[15:8], bus.cq_data_ex[3:2], bus.cq_data[DWIDTH-1:160],
                           bus.cq_data[127:104], bus.cq_data[79], bus.cq_data[63:REG_AW],
                           bus.cq_data[1:0]};
`else
    assign unused_bits = ^{bus.cq_data_ex[15:8], bus.cq_data_ex[3:2], bus.cq_data[DWIDTH-1:160],
                           bus.cq_data[127:104], bus.cq_data[79], bus.cq_data[63:REG_AW],
                           bus.cq_data[1:0], 16'(RD_TOUT)};
`endif

    function automatic logic [DWIDTH-1:0] cpl_beat(input logic [4:0]  la,
                                                   input logic [2:0]  st,
                                                   input logic [15:0] rid,
                                                   input logic [7:0]  tag,
                                                   input logic [31:0] data);
        logic [DWIDTH-1:0] c;
        c          = '0;
        c[6:0]     = {la, 2'b00};
        c[28:16]   = 13'd4;
        c[42:32]   = 11'd1;
        c[45:43]   = st;
        c[63:48]   = rid;
        c[71:64]   = tag;
        c[127:96]  = data;
        return c;
    endfunction

    // Next-state and next-output decode for the request/completion FSM
    always_comb begin
        state_d     = state_q;
        cc_wen_d    = cc_wen_q;
        cc_ex_d     = cc_ex_q;
        cc_data_d   = cc_data_q;
        reg_wr_en_d = 1'b0;
        reg_rd_en_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_be_d    = reg_be_q;
        addr_d      = addr_q;
        rid_d       = rid_q;
        tag_d       = tag_q;
        mrd_d       = mrd_q;
        ur_cnt_d    = ur_cnt_q;
        req_cnt_d   = req_cnt_q;
`ifdef CQ_RD_TOUT_EN
        tout_d      = tout_q;
`endif

        if (accept && sop) begin
            req_cnt_d = req_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept && sop) begin
                    addr_d = beat_addr;
                    rid_d  = bus.cq_data[95:80];
                    tag_d  = bus.cq_data[103:96];
                    mrd_d  = is_mrd;
                    if (!eop) begin
                        state_d = DROP;
                    end else if (is_mwr && dw_one) begin
                        state_d     = WR;
                        reg_wr_en_d = 1'b1;
                        reg_addr_d  = beat_addr;
                        reg_wdata_d = bus.cq_data[159:128];
                        reg_be_d    = bus.cq_data_ex[7:4];
                    end else if (is_mrd && dw_one) begin
                        state_d     = RD_REQ;
                        reg_rd_en_d = 1'b1;
                        reg_addr_d  = beat_addr;
                    end else if (is_mrd) begin
                        state_d   = CPL;
                        cc_wen_d  = 1'b1;
                        cc_ex_d   = 16'h0003;
                        cc_data_d = cpl_beat(beat_addr[6:2], ST_UR, bus.cq_data[95:80],
                                             bus.cq_data[103:96], 32'h0);
                        ur_cnt_d  = ur_cnt_q + 4'd1;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_REQ: begin
                state_d = RD_WAIT;
`ifdef CQ_RD_TOUT_EN
                tout_d  = '0;
`endif
            end
            RD_WAIT: begin
                if (bus.reg_rd_vld) begin
                    state_d   = CPL;
                    cc_wen_d  = 1'b1;
                    cc_ex_d   = 16'h0003;
                    cc_data_d = cpl_beat(addr_q[6:2], ST_SC, rid_q, tag_q, bus.reg_rdata);
                end
`ifdef CQ_RD_TOUT_EN
                else if (tout_q == 16'(RD_TOUT - 1)) begin
                    state_d   = CPL;
                    cc_wen_d  = 1'b1;
                    cc_ex_d   = 16'h0003;
                    cc_data_d = cpl_beat(addr_q[6:2], ST_CA, rid_q, tag_q, 32'hDEADBEEF);
                end else begin
                    tout_d = tout_q + 16'd1;
                end
`endif
            end
            CPL: begin
                if (bus.cc_ready) begin
                    state_d   = IDLE;
                    cc_wen_d  = 1'b0;
                    cc_ex_d   = '0;
                    cc_data_d = '0;
                end
            end
            DROP: begin
                if (accept && eop) begin
                    if (mrd_q) begin
                        state_d   = CPL;
                        cc_wen_d  = 1'b1;
                        cc_ex_d   = 16'h0003;
                        cc_data_d = cpl_beat(addr_q[6:2], ST_UR, rid_q, tag_q, 32'h0);
                        ur_cnt_d  = ur_cnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cq_ready_d = (state_d == IDLE) || (state_d == DROP);
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            cq_ready_q  <= 1'b0;
            cc_wen_q    <= 1'b0;
            cc_ex_q     <= '0;
            cc_data_q   <= '0;
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_be_q    <= '0;
            addr_q      <= '0;
            rid_q       <= '0;
            tag_q       <= '0;
            mrd_q       <= 1'b0;
            ur_cnt_q    <= '0;
            req_cnt_q   <= '0;
`ifdef CQ_RD_TOUT_EN
            tout_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cq_ready_q  <= cq_ready_d;
            cc_wen_q    <= cc_wen_d;
            cc_ex_q     <= cc_ex_d;
            cc_data_q   <= cc_data_d;
            reg_wr_en_q <= reg_wr_en_d;
            reg_rd_en_q <= reg_rd_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_be_q    <= reg_be_d;
            addr_q      <= addr_d;
            rid_q       <= rid_d;
            tag_q       <= tag_d;
            mrd_q       <= mrd_d;
            ur_cnt_q    <= ur_cnt_d;
            req_cnt_q   <= req_cnt_d;
`ifdef CQ_RD_TOUT_EN
            tout_q      <= tout_d;
`endif
        end
    end

    assign bus.cq_ready   = cq_ready_q;
    assign bus.cc_wen     = cc_wen_q;
    assign bus.cc_data_ex = cc_ex_q;
    assign bus.cc_data    = cc_data_q;
    assign bus.reg_wr_en  = reg_wr_en_q;
    assign bus.reg_rd_en  = reg_rd_en_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.reg_be     = reg_be_q;
    assign bus.odbg_info  = {req_cnt_q, ur_cnt_q, state_q};
endmodule

// File: tb/tb_pcie_user_cq_resp.sv
`timescale 1ns/1ps
// Scoreboard bench for pcie_user_cq_resp: expected register writes and
// completions are queued as requests are driven and checked as they appear.
module tb_pcie_user_cq_resp;
    localparam int DW   = 256;
    localparam int AW   = 12;
    localparam int TOUT = 16;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int rd_en_cnt   = 0;
    int cc_cyc      = 0;
    logic [7:0] exp_req = '0;
    logic [3:0] exp_ur  = '0;

    logic [DW-1:0] exp_cpl_q[$];
    wr_t           exp_wr_q[$];
    logic [DW-1:0] mon_e;
    wr_t           mon_w;

    always #5 clk = ~clk;

    pcie_user_cq_resp_if #(.DWIDTH(DW), .REG_AW(AW)) bus ();

    pcie_user_cq_resp #(.DWIDTH(DW), .REG_AW(AW), .RD_TOUT(TOUT)) dut (
        .user_clk  (clk),
        .user_rst_n(rst_n),
        .bus       (bus)
    );

    function automatic logic [DW-1:0] mk_req(input logic [11:0] addr, input logic [10:0] dw,
                                             input logic [3:0] typ, input logic [15:0] rid,
                                             input logic [7:0] tag, input logic [31:0] pay);
        logic [DW-1:0] d;
        d          = '0;
        d[11:2]    = addr[11:2];
        d[74:64]   = dw;
        d[78:75]   = typ;
        d[95:80]   = rid;
        d[103:96]  = tag;
        d[159:128] = pay;
        return d;
    endfunction

    function automatic logic [DW-1:0] mk_cpl(input logic [11:0] addr, input logic [2:0] st,
                                             input logic [15:0] rid, input logic [7:0] tag,
                                             input logic [31:0] data);
        logic [DW-1:0] c;
        c         = '0;
        c[6:2]    = addr[6:2];
        c[28:16]  = 13'd4;
        c[42:32]  = 11'd1;
        c[45:43]  = st;
        c[63:48]  = rid;
        c[71:64]  = tag;
        c[127:96] = data;
        return c;
    endfunction

    // Scoreboard monitor, sampled 1 ns before each rising edge
    always @(negedge clk) begin
        #4;
        if (rst_n === 1'b1) begin
            if (bus.cc_wen === 1'b1) cc_cyc++;
            if (bus.reg_rd_en === 1'b1) rd_en_cnt++;
            if (bus.reg_wr_en === 1'b1) begin
                wr_cnt++;
                vectors++;
                if (exp_wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: addr=%h data=%h be=%h required no write",
                             bus.reg_addr, bus.reg_wdata, bus.reg_be);
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    if ({bus.reg_addr, bus.reg_wdata, bus.reg_be} !== mon_w) begin
                        miscompares++;
                        $display("FAIL wr_bus: addr=%h data=%h be=%h required addr=%h data=%h be=%h",
                                 bus.reg_addr, bus.reg_wdata, bus.reg_be, mon_w.addr, mon_w.data, mon_w.be);
                    end
                end
            end
            if (bus.cc_wen === 1'b1 && bus.cc_ready === 1'b1) begin
                vectors++;
                if (exp_cpl_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cpl_unexpected: cc_data=%h required no completion", bus.cc_data);
                end else begin
                    mon_e = exp_cpl_q.pop_front();
                    if (bus.cc_data !== mon_e || bus.cc_data_ex !== 16'h0003) begin
                        miscompares++;
                        $display("FAIL cpl_data: got ex=%h data=%h required ex=0003 data=%h",
                                 bus.cc_data_ex, bus.cc_data, mon_e);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] ex, input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.cq_data_ex = ex;
        bus.cq_data    = d;
        bus.cq_wen     = 1'b1;
        while (bus.cq_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: cq_ready=%b required 1", bus.cq_ready);
        end else if (ex[0]) begin
            exp_req++;
        end
        @(negedge clk);
        bus.cq_wen     = 1'b0;
        bus.cq_data_ex = '0;
        bus.cq_data    = '0;
    endtask

    task automatic drain_cpl(output bit got, output int lat);
        lat = 0;
        while (bus.cc_wen !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = (bus.cc_wen === 1'b1);
        if (got) begin
            bus.cc_ready = 1'b1;
            @(negedge clk);
            bus.cc_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.cq_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_cq_ready: got %b required 0", bus.cq_ready);
        end
        vectors++;
        if ({bus.cc_wen, bus.cc_data_ex, bus.cc_data} !== '0) begin
            miscompares++; $display("FAIL rst_cc: wen=%b ex=%h data=%h required 0", bus.cc_wen, bus.cc_data_ex, bus.cc_data);
        end
        vectors++;
        if ({bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr, bus.reg_wdata, bus.reg_be} !== '0) begin
            miscompares++; $display("FAIL rst_reg: wr=%b rd=%b addr=%h wdata=%h be=%h required 0",
                                    bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr, bus.reg_wdata, bus.reg_be);
        end
        vectors++;
        if (bus.odbg_info !== 16'h0000) begin
            miscompares++; $display("FAIL rst_dbg: got %h required 0000", bus.odbg_info);
        end
        rst_n   = 1'b1;
        exp_req = '0;
        exp_ur  = '0;
        @(negedge clk);
        vectors++;
        if (bus.cq_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_release_ready: got %b required 1", bus.cq_ready);
        end
    endtask

    task automatic test_write;
        int w0, c0;
        w0 = wr_cnt;
        c0 = cc_cyc;
        exp_wr_q.push_back('{addr: 12'h010, data: 32'h12345678, be: 4'hF});
        send_beat(16'h00F3, mk_req(12'h010, 11'd1, 4'b0001, 16'h0000, 8'h00, 32'h12345678));
        vectors++;
        if (bus.reg_wr_en !== 1'b1 || bus.reg_addr !== 12'h010 || bus.reg_wdata !== 32'h12345678) begin
            miscompares++; $display("FAIL wr_latency: wr_en=%b addr=%h data=%h required 1/010/12345678",
                                    bus.reg_wr_en, bus.reg_addr, bus.reg_wdata);
        end
        exp_wr_q.push_back('{addr: 12'h7FC, data: 32'hA5A50F0F, be: 4'h3});
        send_beat(16'h0033, mk_req(12'h7FC, 11'd1, 4'b0001, 16'h0001, 8'h02, 32'hA5A50F0F));
        // dword count 2 is discarded, as is a stray non-sop beat
        send_beat(16'h00F3, mk_req(12'h020, 11'd2, 4'b0001, 16'h0001, 8'h03, 32'h11111111));
        send_beat(16'h0002, mk_req(12'h030, 11'd1, 4'b0001, 16'h0001, 8'h04, 32'h22222222));
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_cnt - w0 !== 2) begin
            miscompares++; $display("FAIL wr_count: got %0d required 2", wr_cnt - w0);
        end
        vectors++;
        if (cc_cyc !== c0) begin
            miscompares++; $display("FAIL wr_no_cpl: cc_wen cycles %0d required 0", cc_cyc - c0);
        end
        vectors++;
        if (bus.odbg_info[15:8] !== exp_req) begin
            miscompares++; $display("FAIL wr_req_cnt: got %0d required %0d", bus.odbg_info[15:8], exp_req);
        end
    endtask

    task automatic test_rd_vld_ignored;
        int c0;
        c0 = cc_cyc;
        @(negedge clk);
        bus.reg_rdata  = 32'h55AA55AA;
        bus.reg_rd_vld = 1'b1;
        repeat (3) @(negedge clk);
        bus.reg_rd_vld = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (cc_cyc !== c0 || bus.odbg_info[3:0] !== 4'd0) begin
            miscompares++; $display("FAIL vld_ignored: cc_wen cycles %0d state %0d required 0/0",
                                    cc_cyc - c0, bus.odbg_info[3:0]);
        end
    endtask

    task automatic test_read;
        int r0, lat;
        bit got;
        r0 = rd_en_cnt;
        exp_cpl_q.push_back(mk_cpl(12'h024, 3'b000, 16'h0100, 8'h05, 32'hCAFEF00D));
        send_beat(16'h00F3, mk_req(12'h024, 11'd1, 4'b0000, 16'h0100, 8'h05, 32'h0));
        vectors++;
        if (bus.reg_rd_en !== 1'b1 || bus.reg_addr !== 12'h024) begin
            miscompares++; $display("FAIL rd_strobe: rd_en=%b addr=%h required 1/024", bus.reg_rd_en, bus.reg_addr);
        end
        @(negedge clk);
        vectors++;
        if (bus.reg_rd_en !== 1'b0 || bus.odbg_info[3:0] !== 4'd3) begin
            miscompares++; $display("FAIL rd_wait: rd_en=%b state=%0d required 0/3", bus.reg_rd_en, bus.odbg_info[3:0]);
        end
        repeat (2) @(negedge clk);
        bus.reg_rdata  = 32'hCAFEF00D;
        bus.reg_rd_vld = 1'b1;
        @(negedge clk);
        bus.reg_rd_vld = 1'b0;
        bus.reg_rdata  = 32'h0;
        drain_cpl(got, lat);
        vectors++;
        if (!got || lat != 0) begin
            miscompares++; $display("FAIL rd_cpl_latency: got=%0d lat=%0d required 1/0", got, lat);
        end
        vectors++;
        if (bus.cc_wen !== 1'b0 || bus.cq_ready !== 1'b1) begin
            miscompares++; $display("FAIL rd_cpl_done: cc_wen=%b cq_ready=%b required 0/1", bus.cc_wen, bus.cq_ready);
        end
        vectors++;
        if (rd_en_cnt - r0 !== 1) begin
            miscompares++; $display("FAIL rd_strobe_count: got %0d required 1", rd_en_cnt - r0);
        end
    endtask

    task automatic test_unsupported;
        int r0, lat;
        bit got;
        r0 = rd_en_cnt;
        exp_cpl_q.push_back(mk_cpl(12'h03C, 3'b001, 16'hBEEF, 8'h2A, 32'h0));
        exp_ur++;
        send_beat(16'h00F3, mk_req(12'h03C, 11'd2, 4'b0000, 16'hBEEF, 8'h2A, 32'h99999999));
        drain_cpl(got, lat);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL ur_cpl: got none required completion");
        end
        vectors++;
        if (bus.odbg_info[7:4] !== exp_ur || rd_en_cnt !== r0) begin
            miscompares++; $display("FAIL ur_count: ur=%0d rd_strobes=%0d required %0d/0",
                                    bus.odbg_info[7:4], rd_en_cnt - r0, exp_ur);
        end
    endtask

    task automatic test_drop;
        int w0, lat;
        bit got;
        w0 = wr_cnt;
        exp_cpl_q.push_back(mk_cpl(12'h040, 3'b001, 16'h1234, 8'h77, 32'h0));
        exp_ur++;
        send_beat(16'h00F1, mk_req(12'h040, 11'd1, 4'b0000, 16'h1234, 8'h77, 32'h0));
        vectors++;
        if (bus.odbg_info[3:0] !== 4'd5 || bus.cq_ready !== 1'b1) begin
            miscompares++; $display("FAIL drop_state: state=%0d cq_ready=%b required 5/1", bus.odbg_info[3:0], bus.cq_ready);
        end
        send_beat(16'h0000, {8{32'h0BADCAFE}});
        send_beat(16'h0002, {8{32'h0BADCAFE}});
        drain_cpl(got, lat);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL drop_ur_cpl: got none required completion");
        end
        send_beat(16'h00F1, mk_req(12'h050, 11'd1, 4'b0001, 16'h1234, 8'h78, 32'h77777777));
        send_beat(16'h0002, {8{32'h0BADCAFE}});
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt !== w0 || bus.odbg_info[3:0] !== 4'd0 || bus.cq_ready !== 1'b1) begin
            miscompares++; $display("FAIL drop_mwr: writes=%0d state=%0d cq_ready=%b required 0/0/1",
                                    wr_cnt - w0, bus.odbg_info[3:0], bus.cq_ready);
        end
        vectors++;
        if (bus.odbg_info[15:4] !== {exp_req, exp_ur}) begin
            miscompares++; $display("FAIL drop_counts: got %h required %h", bus.odbg_info[15:4], {exp_req, exp_ur});
        end
    endtask

    task automatic test_backpressure;
        int n, lat;
        bit got;
        logic [DW-1:0] snap;
        exp_cpl_q.push_back(mk_cpl(12'h0A8, 3'b001, 16'h00FF, 8'hC3, 32'h0));
        exp_ur++;
        send_beat(16'h00F3, mk_req(12'h0A8, 11'd3, 4'b0000, 16'h00FF, 8'hC3, 32'h0));
        n = 0;
        while (bus.cc_wen !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.cc_wen !== 1'b1) begin
            miscompares++; $display("FAIL bp_cpl_start: cc_wen=%b required 1", bus.cc_wen);
        end
        snap = bus.cc_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.cc_wen !== 1'b1 || bus.cc_data !== snap || bus.cq_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_stall_%0d: wen=%b cq_ready=%b data=%h required 1/0/%h",
                                        i, bus.cc_wen, bus.cq_ready, bus.cc_data, snap);
            end
        end
        drain_cpl(got, lat);
        vectors++;
        if (!got || bus.cc_wen !== 1'b0) begin
            miscompares++; $display("FAIL bp_release: got=%0d cc_wen=%b required 1/0", got, bus.cc_wen);
        end
    endtask

    task automatic test_timeout;
        int n, lat, c0;
        bit got;
`ifdef CQ_RD_TOUT_EN
        c0 = cc_cyc;
        exp_cpl_q.push_back(mk_cpl(12'h100, 3'b100, 16'h0042, 8'h11, 32'hDEADBEEF));
        send_beat(16'h00F3, mk_req(12'h100, 11'd1, 4'b0000, 16'h0042, 8'h11, 32'h0));
        n = 0;
        while (bus.cc_wen !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 17) begin
            miscompares++; $display("FAIL tout_latency: cc_wen after %0d cycles from strobe required 17 (cc_wen before=%0d)",
                                    n, cc_cyc - c0);
        end
        drain_cpl(got, lat);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL tout_cpl: got none required CA completion");
        end
`else
        c0 = cc_cyc;
        exp_cpl_q.push_back(mk_cpl(12'h100, 3'b000, 16'h0042, 8'h11, 32'h0BADF00D));
        send_beat(16'h00F3, mk_req(12'h100, 11'd1, 4'b0000, 16'h0042, 8'h11, 32'h0));
        repeat (40) @(negedge clk);
        vectors++;
        if (cc_cyc !== c0 || bus.odbg_info[3:0] !== 4'd3) begin
            miscompares++; $display("FAIL no_tout_wait: cc_wen cycles %0d state %0d required 0/3", cc_cyc - c0, bus.odbg_info[3:0]);
        end
        bus.reg_rdata  = 32'h0BADF00D;
        bus.reg_rd_vld = 1'b1;
        @(negedge clk);
        bus.reg_rd_vld = 1'b0;
        drain_cpl(got, lat);
        n = lat;
        vectors++;
        if (!got || n != 0) begin
            miscompares++; $display("FAIL no_tout_cpl: got=%0d lat=%0d required 1/0", got, n);
        end
`endif
    endtask

    task automatic test_reset_inflight;
        int c0, w0;
        send_beat(16'h00F3, mk_req(12'h0F4, 11'd1, 4'b0000, 16'h0777, 8'h3E, 32'h0));
        @(negedge clk);
        vectors++;
        if (bus.odbg_info[3:0] !== 4'd3) begin
            miscompares++; $display("FAIL inflight_state: got %0d required 3", bus.odbg_info[3:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.cq_ready, bus.cc_wen, bus.cc_data_ex, bus.cc_data, bus.reg_wr_en, bus.reg_rd_en,
             bus.reg_addr, bus.reg_wdata, bus.reg_be, bus.odbg_info} !== '0) begin
            miscompares++; $display("FAIL inflight_async_clear: ready=%b wen=%b addr=%h dbg=%h required all 0",
                                    bus.cq_ready, bus.cc_wen, bus.reg_addr, bus.odbg_info);
        end
        exp_req = '0;
        exp_ur  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cc_cyc;
        w0 = wr_cnt;
        @(negedge clk);
        bus.reg_rdata  = 32'h12121212;
        bus.reg_rd_vld = 1'b1;
        @(negedge clk);
        bus.reg_rd_vld = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (cc_cyc !== c0) begin
            miscompares++; $display("FAIL inflight_stale_cpl: cc_wen cycles %0d required 0", cc_cyc - c0);
        end
        exp_wr_q.push_back('{addr: 12'h0C8, data: 32'h600DF00D, be: 4'hC});
        send_beat(16'h00C3, mk_req(12'h0C8, 11'd1, 4'b0001, 16'h0000, 8'h01, 32'h600DF00D));
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt - w0 !== 1 || bus.odbg_info[15:8] !== exp_req) begin
            miscompares++; $display("FAIL inflight_next_wr: writes=%0d req_cnt=%0d required 1/%0d",
                                    wr_cnt - w0, bus.odbg_info[15:8], exp_req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cq_data_ex = '0;
        bus.cq_data    = '0;
        bus.cq_wen     = 1'b0;
        bus.cc_ready   = 1'b0;
        bus.reg_rdata  = '0;
        bus.reg_rd_vld = 1'b0;

        test_reset();
        test_write();
        test_rd_vld_ignored();
        test_read();
        test_unsupported();
        test_drop();
        test_backpressure();
        test_timeout();
        test_reset_inflight();

        repeat (2) @(negedge clk);
        vectors++;
        if (exp_cpl_q.size() != 0 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: %0d completions %0d writes outstanding required 0/0",
                                    exp_cpl_q.size(), exp_wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pcie_user_cq_resp.md
PCIE_USER_CQ_RESP -- requirements
Module: pcie_user_cq_resp

Interface
REQ-001 SHALL have parameter DWIDTH, default 256: width of cq_data and cc_data, minimum 256.
REQ-002 SHALL have parameter REG_AW, default 12: register byte-address width.
REQ-003 SHALL have parameter RD_TOUT, default 1024: read-wait timeout in user_clk cycles, 16-bit.
REQ-004 SHALL have port user_clk, input, 1: the only clock; all logic rising-edge.
REQ-005 SHALL have port user_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port cq_data_ex, input, 16: [0] sop, [1] eop, [7:4] first_be, rest ignored.
REQ-007 SHALL have port cq_data, input, DWIDTH: host request beat.
REQ-008 SHALL have port cq_wen, input, 1: beat valid.
REQ-009 SHALL have port cq_ready, output, 1: beat accepted when cq_wen & cq_ready.
REQ-010 SHALL have port cc_data_ex, output, 16: [0] sop, [1] eop, rest 0.
REQ-011 SHALL have port cc_data, output, DWIDTH: completion beat.
REQ-012 SHALL have port cc_wen, output, 1: beat valid.
REQ-013 SHALL have port cc_ready, input, 1: beat consumed when cc_wen & cc_ready.
REQ-014 SHALL have ports reg_wr_en (out, 1), reg_rd_en (out, 1), reg_addr (out, REG_AW), reg_wdata (out, 32), reg_be (out, 4), reg_rdata (in, 32), reg_rd_vld (in, 1): register bus.
REQ-015 SHALL have port odbg_info, output, 16: [3:0] FSM state, [7:4] UR count, [15:8] accepted request count; the counts wrap.

Function
REQ-016 SHALL decode the sop beat: addr cq_data[REG_AW-1:2], dword count [74:64], req type [78:75] (0000 MRd, 0001 MWr), requester ID [95:80], tag [103:96], write payload [159:128].
REQ-017 SHALL use FSM states IDLE, WR, RD_REQ, RD_WAIT, CPL, DROP; cq_ready is high only in IDLE and DROP.
REQ-018 SHALL, in IDLE on an accepted sop&eop beat: MWr with dword count 1 -> WR; MRd with dword count 1 -> RD_REQ; other MRd -> CPL with UR status; anything else -> IDLE, discarded.
REQ-019 SHALL, in IDLE on an accepted sop beat without eop, go to DROP, which accepts beats until eop; an MRd in DROP is completed UR via CPL, anything else returns to IDLE.
REQ-020 SHALL, in WR, pulse reg_wr_en for one cycle with reg_addr, reg_wdata and reg_be=first_be, then return to IDLE. Accept-to-strobe latency is 1 cycle.
REQ-021 SHALL, in RD_REQ, pulse reg_rd_en for one cycle and enter RD_WAIT; in RD_WAIT, capture reg_rdata on reg_rd_vld and enter CPL with SC status.
REQ-022 SHALL build a single-beat completion: [6:0] lower address ({addr[6:2],2'b00}), [28:16] byte count 4, [42:32] dword count 1, [45:43] status (000 SC, 001 UR, 100 CA), [63:48] requester ID, [71:64] tag, [127:96] data (0 for UR), all other bits 0; cc_data_ex = 16'h0003.
REQ-023 SHALL hold cc_wen and cc_data stable in CPL until cc_ready, then go to IDLE with cc_wen low the next cycle.
REQ-024 SHALL ignore reg_rd_vld outside RD_WAIT.
REQ-025 SHALL increment the UR count per UR completion and the request count per accepted sop beat.

Reset
REQ-026 SHALL, while user_rst_n is low, force state IDLE, cq_ready 0, cc_wen 0, cc_data/cc_data_ex 0, reg_wr_en/reg_rd_en 0, reg_addr/reg_wdata/reg_be 0 and counters 0, asynchronously.
REQ-027 SHALL abandon any in-flight request on reset without issuing a completion, and SHALL raise cq_ready on the first clock edge after user_rst_n is released.

Configuration
REQ-028 SHALL, with macro CQ_RD_TOUT_EN defined, count RD_WAIT cycles and, if the count reaches RD_TOUT without reg_rd_vld, go to CPL with CA status and data 32'hDEADBEEF.
REQ-029 SHALL, with CQ_RD_TOUT_EN undefined, wait in RD_WAIT indefinitely and generate no timeout logic.

Verification
REQ-030 SHALL cover: MWr addr 0x010, data 0x12345678, be 0xF -> one reg_wr_en pulse, reg_addr 0x010, reg_wdata 0x12345678, no cc_wen.
REQ-031 SHALL cover: MRd addr 0x024, tag 0x05, ID 0x0100, reg_rdata 0xCAFEF00D after 3 cycles -> completion status 000, tag 0x05, [63:48]=0x0100, [6:0]=0x24, data 0xCAFEF00D.
REQ-032 SHALL cover: MRd with dword count 2 -> UR completion with data 0, UR count 1, no reg_rd_en.
REQ-033 SHALL cover: cc_ready held low 10 cycles in CPL -> cc_wen and cc_data stable; cq_ready stays 0 throughout.
REQ-034 SHALL cover: with CQ_RD_TOUT_EN and RD_TOUT=16, no reg_rd_vld -> CA completion with data 0xDEADBEEF exactly 16 cycles after entering RD_WAIT.
REQ-035 SHALL cover: user_rst_n low in RD_WAIT -> all outputs 0 immediately; after release, no stale completion and the next MWr is serviced normally.
